// File: rtl/spi_adc_sampler.sv
// SPI master for 16-bit serial-ADC Pmods: frames free-running or on start, extracts a field, optionally averages.
// Sample valid in the CS-rising cycle, HALF_DIV*(1+2*FRAME_BITS) after frame start; no backpressure, consumer must take each pulse.
module spi_adc_sampler #(
  parameter int HALF_DIV      = 50,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_MSB      = 11,
  parameter int DATA_LSB      = 4,
  parameter int SAMPLE_PERIOD = 10_000_000,
  parameter int AVG_LOG2      = 0,
  parameter int AUTO          = 1
) (
  input  logic                         clk_in,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         SDO,
  output logic                         CS,
  output logic                         SCK,
  output logic [DATA_MSB-DATA_LSB:0]   sample,
  output logic                         sample_valid,
  output logic [DATA_MSB-DATA_LSB:0]   avg,
  output logic                         avg_valid,
  output logic                         busy
);

  localparam int DATA_W = DATA_MSB - DATA_LSB + 1;
  localparam int DIV_W  = $clog2(2 * HALF_DIV);
  localparam int BIT_W  = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int PER_W  = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_QUIET} state_t;

  state_t                r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div, w_div_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic                  r_hi, w_hi_nxt;
  logic [PER_W-1:0]      r_per;
  logic                  r_pend;
  logic                  r_sdo_s1, r_sdo_s2;
  logic [FRAME_BITS-1:0] r_shift;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cs, r_sck, r_sv, r_av, r_busy;
  logic [DATA_W-1:0]     r_sample, r_avg;

  logic                  w_div_last, w_wrap, w_req, w_shift_en, w_done, w_grp_done;
  logic                  w_cs_nxt, w_sck_nxt, w_busy_nxt;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [DATA_W-1:0]     w_field;
  logic [ACC_W-1:0]      w_acc_sum;
  logic                  w_unused;

  assign w_div_last  = (r_div == DIV_W'(HALF_DIV - 1));
  assign w_wrap      = (r_per == PER_W'(SAMPLE_PERIOD - 1));
  assign w_req       = (AUTO != 0) ? (w_wrap || r_pend) : start;
  assign w_shift_en  = (r_state == S_SHIFT) && r_hi && w_div_last;
  assign w_shift_nxt = {r_shift[FRAME_BITS-2:0], r_sdo_s2};
  // The final bit lands on the same edge as the DONE entry, so the field comes from the post-shift value.
  assign w_field     = w_shift_nxt[DATA_MSB:DATA_LSB];
  assign w_acc_sum   = r_acc + ACC_W'(w_field);
  assign w_grp_done  = (r_cnt == CNT_W'((1 << AVG_LOG2) - 1));
  assign w_done      = (r_state == S_SHIFT) && (w_state_nxt == S_DONE);
  assign w_unused    = ^{r_shift[FRAME_BITS-1], w_shift_nxt};

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_hi    <= w_hi_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div + 1'b1;
    w_bit_nxt   = r_bit;
    w_hi_nxt    = r_hi;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (w_req) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_state_nxt = S_SHIFT;
          w_div_nxt   = '0;
          w_hi_nxt    = 1'b0;
          w_bit_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (w_div_last) begin
          w_div_nxt = '0;
          if (!r_hi) begin
            w_hi_nxt = 1'b1;
          end else begin
            w_hi_nxt = 1'b0;
            if (r_bit == BIT_W'(FRAME_BITS - 1)) w_state_nxt = S_DONE;
            else                                 w_bit_nxt   = r_bit + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_QUIET;
        w_div_nxt   = '0;
      end
      S_QUIET: begin
        if (r_div == DIV_W'(2 * HALF_DIV - 1)) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_cs_nxt   = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
    w_sck_nxt  = !((w_state_nxt == S_SHIFT) && !w_hi_nxt);
    w_busy_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) || (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_sdo_s1 <= 1'b0;
      r_sdo_s2 <= 1'b0;
      r_cs     <= 1'b1;
      r_sck    <= 1'b1;
      r_busy   <= 1'b0;
      r_per    <= '0;
      r_pend   <= 1'b0;
      r_shift  <= '0;
      r_sv     <= 1'b0;
      r_av     <= 1'b0;
      r_sample <= '0;
      r_avg    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_sdo_s1 <= SDO;
      r_sdo_s2 <= r_sdo_s1;
      r_cs     <= w_cs_nxt;
      r_sck    <= w_sck_nxt;
      r_busy   <= w_busy_nxt;
      r_per    <= w_wrap ? '0 : r_per + 1'b1;
      // One remembered wrap while a frame is in flight; extra wraps collapse into it.
      r_pend   <= (r_state != S_IDLE) && (r_pend || w_wrap);
      if (w_shift_en) r_shift <= w_shift_nxt;
      r_sv <= w_done;
      r_av <= w_done && w_grp_done;
      if (w_done) begin
        r_sample <= w_field;
        if (w_grp_done) begin
          r_avg <= DATA_W'(w_acc_sum >> AVG_LOG2);
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign CS           = r_cs;
  assign SCK          = r_sck;
  assign busy         = r_busy;
  assign sample       = r_sample;
  assign sample_valid = r_sv;
  assign avg          = r_avg;
  assign avg_valid    = r_av;

endmodule
